oled_sdi_monitor: RTL and testbench
===================================

# oled_sdi_monitor

Synthesizable receive-side decoder for the 4-wire OLED serial link (nCS, DnC, SDIN, SCLK) driven by the cycle computer's OLED manager. It deserialises bytes, interprets the SSD1351-style command subset (column window, row window, pixel write, normal/inverse display), and emits one addressed 16-bit pixel per completed colour pair. It sits on the same HCLK as the transmitter. It feeds the display model, scoreboards, and an optional on-chip frame checker.

## Interface
- `ColMax`, default 127: highest column address; x arguments are masked to 7 bits, then limited by this value.
- `RowMax`, default 127: highest row address.
- `HCLK`, in, 1: system clock. All link inputs are sampled on its rising edge with no synchroniser, because they are same-domain.
- `HRESETn`, in, 1: reset, synchronous and active-low.
- `nCS`, in, 1: chip select, active low.
- `DnC`, in, 1: 0 = command, 1 = data. Sampled with the last bit of each byte.
- `SDIN`, in, 1: serial data, MSB first.
- `SCLK`, in, 1: serial clock. Data is captured on its rising edge.
- `byte_valid`, out, 1: one-cycle pulse when a byte completes.
- `byte_data`, out, 8: the completed byte.
- `byte_dnc`, out, 1: DnC value of the completed byte.
- `pix_valid`, out, 1: one-cycle pulse when a pixel is written.
- `pix_x`, out, 7: column of the written pixel.
- `pix_y`, out, 7: row of the written pixel.
- `pix_data`, out, 16: pixel value, `{first_byte, second_byte}`.
- `inverse`, out, 1: 0 after command A6, 1 after command A7.
- `frame_err`, out, 1: one-cycle pulse when nCS deasserts mid-byte.

## Operation
- **Bit capture**
  - `sclk_q` is a registered copy of SCLK.
  - A sample event occurs when `SCLK && !sclk_q && !nCS`.
  - On a sample event, SDIN shifts into `shreg`, and `bitcnt` counts 0..7.
  - On the 8th sample, the byte is latched together with the current DnC.
- **Chip-select abort:** if nCS is high and `bitcnt != 0`:
  - `bitcnt` is cleared and the partial byte is dropped;
  - `frame_err` pulses;
  - the decoder state is unaffected.
- **Decoder FSM**
  - States: `Idle`, `ColA`, `ColB`, `RowA`, `RowB`, `PixHi`, `PixLo`.
  - Any command byte (`byte_dnc = 0`) is handled from every state:
    - 0x15 → `ColA`;
    - 0x75 → `RowA`;
    - 0x5C → load `x = x_start`, `y = y_start` → `PixHi`;
    - 0xA6 → `inverse` = 0, go to `Idle`;
    - 0xA7 → `inverse` = 1, go to `Idle`;
    - any other command → `Idle`.
  - A pending high byte is discarded by any command byte.
- **Data bytes, by state**
  - `ColA`: `x_start = min(d & 7F, ColMax)` → `ColB`.
  - `ColB`: `x_end` is set the same way → `Idle`.
  - `RowA`: sets `y_start` → `RowB`.
  - `RowB`: sets `y_end` → `Idle`.
  - `PixHi`: latch the high byte → `PixLo`.
  - `PixLo`: emit the pixel at (x, y) → `PixHi`.
  - `Idle`: the byte is ignored.
- **Address advance after each pixel**
  - If `x == x_end` or `x == ColMax`:
    - `x = x_start`;
    - then if `y == y_end` or `y == RowMax`, `y = y_start`; otherwise `y = y + 1`.
  - Otherwise `x = x + 1`.
  - If start > end, the wrap falls back to the `ColMax`/`RowMax` bound.
- **Reset values:**
  - all outputs 0;
  - `x_start` = `y_start` = 0, `x_end` = `ColMax`, `y_end` = `RowMax`;
  - FSM in `Idle`, `bitcnt` = 0, `sclk_q` = 0.

## Timing
- **Byte latency:** `byte_valid` is registered and asserts in the cycle after the HCLK edge that samples the 8th SCLK-high bit.
- **Pixel latency:** `pix_valid` asserts one cycle after the `byte_valid` of the low byte, i.e. 2 cycles after the last SCLK-high cycle.
- **Output hold:** `pix_x`, `pix_y` and `pix_data` hold their values until the next pixel.
- **Minimum link timing:** SCLK low ≥1 cycle and high ≥1 cycle. This matches the transmitter's ChangeData/SendData alternation, i.e. HCLK/2, 8 bits per 16 cycles.
- **Back-to-back bytes:** with nCS remaining low, no bits are lost.
- **Simultaneous events:** if a sample event and nCS rising happen in the same cycle, the sample is taken first. The abort applies only when the resulting `bitcnt` is nonzero.
- **Reset mid-stream:** clears all state on the next HCLK edge. The first subsequent data byte is ignored (FSM in `Idle`).

## Structure
- **Package `oled_pkg`**
  - Command constants: `SetX` = 0x15, `SetY` = 0x75, `SetPixel` = 0x5C, `DispNormal` = 0xA6, `DispInverse` = 0xA7.
  - Colour constants: `ColourBlue` = 0x063C, `ColourWhite` = 0xFFFF.
  - The decoder state enum.
- **Sub-module `oled_sdi_deserializer`:** edge detect, shift register, `bitcnt`, the byte outputs and `frame_err`.
- **Top-level `oled_sdi_monitor`:** instantiates it and contains the decoder FSM and the address counters.

## Test plan
- **Column window:** send 0x15 (cmd), then 0x0E, 0x15 (data) → three `byte_valid` pulses; window becomes x = 14..21; no `pix_valid`.
- **Full block write:**
  - Stimulus: 0x15, 0x0E, 0x15; 0x75, 0x1F, 0x2B; 0x5C; then 104 pairs of 06,3C.
  - Expect 104 `pix_valid` pulses, all with `pix_data` = 0x063C.
  - Coordinates: 1st (14, 31); 8th (21, 31); 9th (14, 32); 104th (21, 43).
  - A 105th pixel lands on (14, 31).
- **Display mode:** command 0xA7 → `inverse` = 1 two cycles after the byte; command 0xA6 → `inverse` = 0.
- **Chip-select abort:** raise nCS after 5 bits → single-cycle `frame_err`, no `byte_valid`; the next full byte 0x75 decodes correctly.
- **Orphan pixel byte:** in pixel mode, send one data byte 0xFF, then command 0x15 → no `pix_valid`; FSM enters `ColA`.
- **Reset mid-pixel:** assert `HRESETn` = 0 for 1 cycle after a high byte →
  - all outputs 0;
  - the next data byte produces no pixel;
  - window reset to 0..127.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared constants, decoder state type and address helper for the OLED serial link monitor.
package oled_pkg;

  localparam logic [7:0] SetX        = 8'h15;
  localparam logic [7:0] SetY        = 8'h75;
  localparam logic [7:0] SetPixel    = 8'h5C;
  localparam logic [7:0] DispNormal  = 8'hA6;
  localparam logic [7:0] DispInverse = 8'hA7;

  localparam logic [15:0] ColourBlue  = 16'h063C;
  localparam logic [15:0] ColourWhite = 16'hFFFF;

  typedef enum logic [2:0] {
    Idle  = 3'd0,
    ColA  = 3'd1,
    ColB  = 3'd2,
    RowA  = 3'd3,
    RowB  = 3'd4,
    PixHi = 3'd5,
    PixLo = 3'd6
  } state_t;

  // Address arguments use only the low 7 bits, then saturate at the panel edge.
  function automatic logic [6:0] clamp_addr(input logic [7:0] d, input logic [6:0] lim);
    logic [6:0] m;
    m = d[6:0];
    return (m > lim) ? lim : m;
  endfunction

endpackage

// File: rtl/oled_sdi_monitor_if.sv
// Link wires from the OLED manager plus the decoded byte/pixel outputs of the monitor.
interface oled_sdi_monitor_if;
  import oled_pkg::*;

  logic        nCS;
  logic        DnC;
  logic        SDIN;
  logic        SCLK;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_dnc;
  logic        pix_valid;
  logic [6:0]  pix_x;
  logic [6:0]  pix_y;
  logic [15:0] pix_data;
  logic        inverse;
  logic        frame_err;

  modport master (
    output nCS, DnC, SDIN, SCLK,
    input  byte_valid, byte_data, byte_dnc, pix_valid, pix_x, pix_y, pix_data, inverse, frame_err
  );

  modport slave (
    input  nCS, DnC, SDIN, SCLK,
    output byte_valid, byte_data, byte_dnc, pix_valid, pix_x, pix_y, pix_data, inverse, frame_err
  );
endinterface

// File: rtl/oled_sdi_deserializer.sv
// Same-clock SCLK edge detector and 8-bit MSB-first shifter; flags bytes cut short by nCS.
module oled_sdi_deserializer
  import oled_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ncs_i,
  input  logic       dnc_i,
  input  logic       sdin_i,
  input  logic       sclk_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       byte_dnc_o,
  output logic       frame_err_o
);

  logic       sclk_q;
  logic [6:0] shreg_q, shreg_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic       byte_valid_q, byte_valid_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic       byte_dnc_q, byte_dnc_d;
  logic       frame_err_q, frame_err_d;
  logic       sample_s;

  assign sample_s = sclk_i && !sclk_q && !ncs_i;

  // Shift on each sample; an abort is judged on the post-sample bit count.
  always_comb begin
    shreg_d      = shreg_q;
    bitcnt_d     = bitcnt_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    byte_dnc_d   = byte_dnc_q;
    frame_err_d  = 1'b0;
    if (sample_s) begin
      shreg_d  = {shreg_q[5:0], sdin_i};
      bitcnt_d = bitcnt_q + 3'd1;
      if (bitcnt_q == 3'd7) begin
        byte_valid_d = 1'b1;
        byte_data_d  = {shreg_q, sdin_i};
        byte_dnc_d   = dnc_i;
      end else begin
        byte_valid_d = 1'b0;
      end
    end else begin
      shreg_d = shreg_q;
    end
    if (ncs_i && (bitcnt_d != 3'd0)) begin
      bitcnt_d    = 3'd0;
      frame_err_d = 1'b1;
    end else begin
      frame_err_d = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sclk_q       <= 1'b0;
      shreg_q      <= 7'd0;
      bitcnt_q     <= 3'd0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= 8'd0;
      byte_dnc_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sclk_q       <= sclk_i;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      byte_dnc_q   <= byte_dnc_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign byte_valid_o = byte_valid_q;
  assign byte_data_o  = byte_data_q;
  assign byte_dnc_o   = byte_dnc_q;
  assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/oled_sdi_monitor.sv
// Receive-side decoder for the 4-wire OLED link: command subset, address window and pixel output.
module oled_sdi_monitor
  import oled_pkg::*;
#(
  parameter int unsigned ColMax = 127,
  parameter int unsigned RowMax = 127
) (
  input  logic HCLK,
  input  logic HRESETn,
  oled_sdi_monitor_if.slave bus
);

  localparam logic [6:0] ColMaxL = 7'(ColMax);
  localparam logic [6:0] RowMaxL = 7'(RowMax);

  logic       byte_valid_s;
  logic [7:0] byte_data_s;
  logic       byte_dnc_s;
  logic       frame_err_s;

  oled_sdi_deserializer u_deser (
    .clk_i        (HCLK),
    .rst_ni       (HRESETn),
    .ncs_i        (bus.nCS),
    .dnc_i        (bus.DnC),
    .sdin_i       (bus.SDIN),
    .sclk_i       (bus.SCLK),
    .byte_valid_o (byte_valid_s),
    .byte_data_o  (byte_data_s),
    .byte_dnc_o   (byte_dnc_s),
    .frame_err_o  (frame_err_s)
  );

  state_t      state_q, state_d;
  logic [6:0]  x_start_q, x_start_d, x_end_q, x_end_d;
  logic [6:0]  y_start_q, y_start_d, y_end_q, y_end_d;
  logic [6:0]  x_q, x_d, y_q, y_d;
  logic [7:0]  hi_q, hi_d;
  logic        pix_valid_q, pix_valid_d;
  logic [6:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [15:0] pix_data_q, pix_data_d;
  logic        inverse_q, inverse_d;

  // Commands override any state, including a half-received pixel; data is routed by state.
  always_comb begin
    state_d     = state_q;
    x_start_d   = x_start_q;
    x_end_d     = x_end_q;
    y_start_d   = y_start_q;
    y_end_d     = y_end_q;
    x_d         = x_q;
    y_d         = y_q;
    hi_d        = hi_q;
    pix_valid_d = 1'b0;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_data_d  = pix_data_q;
    inverse_d   = inverse_q;
    if (byte_valid_s) begin
      if (!byte_dnc_s) begin
        case (byte_data_s)
          SetX:        state_d = ColA;
          SetY:        state_d = RowA;
          SetPixel: begin
            x_d     = x_start_q;
            y_d     = y_start_q;
            state_d = PixHi;
          end
          DispNormal: begin
            inverse_d = 1'b0;
            state_d   = Idle;
          end
          DispInverse: begin
            inverse_d = 1'b1;
            state_d   = Idle;
          end
          default:     state_d = Idle;
        endcase
      end else begin
        case (state_q)
          ColA: begin
            x_start_d = clamp_addr(byte_data_s, ColMaxL);
            state_d   = ColB;
          end
          ColB: begin
            x_end_d = clamp_addr(byte_data_s, ColMaxL);
            state_d = Idle;
          end
          RowA: begin
            y_start_d = clamp_addr(byte_data_s, RowMaxL);
            state_d   = RowB;
          end
          RowB: begin
            y_end_d = clamp_addr(byte_data_s, RowMaxL);
            state_d = Idle;
          end
          PixHi: begin
            hi_d    = byte_data_s;
            state_d = PixLo;
          end
          PixLo: begin
            pix_valid_d = 1'b1;
            pix_x_d     = x_q;
            pix_y_d     = y_q;
            pix_data_d  = {hi_q, byte_data_s};
            state_d     = PixHi;
            // The panel edge also ends a line, so start > end still wraps.
            if ((x_q == x_end_q) || (x_q == ColMaxL)) begin
              x_d = x_start_q;
              if ((y_q == y_end_q) || (y_q == RowMaxL)) begin
                y_d = y_start_q;
              end else begin
                y_d = y_q + 7'd1;
              end
            end else begin
              x_d = x_q + 7'd1;
            end
          end
          default: state_d = state_q;
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // Decoder registers with synchronous active-low reset.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q     <= Idle;
      x_start_q   <= 7'd0;
      x_end_q     <= ColMaxL;
      y_start_q   <= 7'd0;
      y_end_q     <= RowMaxL;
      x_q         <= 7'd0;
      y_q         <= 7'd0;
      hi_q        <= 8'd0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= 7'd0;
      pix_y_q     <= 7'd0;
      pix_data_q  <= 16'd0;
      inverse_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_start_q   <= x_start_d;
      x_end_q     <= x_end_d;
      y_start_q   <= y_start_d;
      y_end_q     <= y_end_d;
      x_q         <= x_d;
      y_q         <= y_d;
      hi_q        <= hi_d;
      pix_valid_q <= pix_valid_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_data_q  <= pix_data_d;
      inverse_q   <= inverse_d;
    end
  end

  assign bus.byte_valid = byte_valid_s;
  assign bus.byte_data  = byte_data_s;
  assign bus.byte_dnc   = byte_dnc_s;
  assign bus.frame_err  = frame_err_s;
  assign bus.pix_valid  = pix_valid_q;
  assign bus.pix_x      = pix_x_q;
  assign bus.pix_y      = pix_y_q;
  assign bus.pix_data   = pix_data_q;
  assign bus.inverse    = inverse_q;

endmodule

// File: tb/tb_oled_sdi_monitor.sv
// Randomised scoreboard bench for oled_sdi_monitor against a byte-level reference model.
module tb_oled_sdi_monitor;
  import oled_pkg::*;

  logic HCLK;
  logic HRESETn;
  oled_sdi_monitor_if bus ();

  oled_sdi_monitor dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [6:0]  x;
    logic [6:0]  y;
    logic [15:0] d;
  } pix_t;

  logic [8:0] byte_q[$];
  pix_t       pix_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int ferr_seen = 0, ferr_exp = 0;
  int pix_seen = 0, pix_exp = 0;

  // Reference model: meaning of the next data byte, window, cursor, display mode.
  localparam int M_IDLE = 0, M_XS = 1, M_XE = 2, M_YS = 3, M_YE = 4, M_HI = 5, M_LO = 6;
  int m_mode, m_xs, m_xe, m_ys, m_ye, m_x, m_y, m_hi;
  bit m_inv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic int lim127(input int v);
    return ((v % 128) > 127) ? 127 : (v % 128);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_xs = 0; m_xe = 127; m_ys = 0; m_ye = 127;
    m_x = 0; m_y = 0; m_hi = 0; m_inv = 1'b0;
  endtask

  task automatic model_byte(input bit dnc, input logic [7:0] d);
    pix_t p;
    byte_q.push_back({dnc, d});
    if (!dnc) begin
      m_mode = M_IDLE;
      if (d == 8'h15) m_mode = M_XS;
      else if (d == 8'h75) m_mode = M_YS;
      else if (d == 8'h5C) begin m_x = m_xs; m_y = m_ys; m_mode = M_HI; end
      else if (d == 8'hA6) m_inv = 1'b0;
      else if (d == 8'hA7) m_inv = 1'b1;
    end else begin
      case (m_mode)
        M_XS: begin m_xs = lim127(int'(d)); m_mode = M_XE; end
        M_XE: begin m_xe = lim127(int'(d)); m_mode = M_IDLE; end
        M_YS: begin m_ys = lim127(int'(d)); m_mode = M_YE; end
        M_YE: begin m_ye = lim127(int'(d)); m_mode = M_IDLE; end
        M_HI: begin m_hi = int'(d); m_mode = M_LO; end
        M_LO: begin
          p.x = 7'(m_x); p.y = 7'(m_y); p.d = {8'(m_hi), d};
          pix_q.push_back(p);
          pix_exp++;
          m_mode = M_HI;
          if (m_x == m_xe || m_x == 127) begin
            m_x = m_xs;
            m_y = (m_y == m_ye || m_y == 127) ? m_ys : m_y + 1;
          end else m_x = m_x + 1;
        end
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic send_bits(input bit dnc, input logic [7:0] d, input int nbits);
    logic [7:0] v;
    v = d;
    bus.nCS = 1'b0;
    bus.DnC = dnc;
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.SDIN = v[i];
      bus.SCLK = 1'b0;
      tick();
      bus.SCLK = 1'b1;
      tick();
    end
  endtask

  task automatic xfer(input bit dnc, input logic [7:0] d);
    model_byte(dnc, d);
    send_bits(dnc, d, 8);
  endtask

  task automatic abort_after(input int nbits);
    send_bits(1'b1, 8'($urandom_range(0, 255)), nbits);
    bus.SCLK = 1'b0;
    bus.nCS  = 1'b1;
    ferr_exp++;
    tick();
    tick();
    bus.nCS = 1'b0;
  endtask

  task automatic pixels(input int n, input bit random_data);
    for (int i = 0; i < n; i++) begin
      if (random_data) begin
        xfer(1'b1, 8'($urandom_range(0, 255)));
        xfer(1'b1, 8'($urandom_range(0, 255)));
      end else begin
        xfer(1'b1, ColourBlue[15:8]);
        xfer(1'b1, ColourBlue[7:0]);
      end
    end
  endtask

  function automatic logic [7:0] rand_addr();
    case ($urandom_range(0, 2))
      0:       return 8'($urandom_range(0, 255));
      1:       return 8'($urandom_range(0, 5));
      default: return 8'($urandom_range(122, 127));
    endcase
  endfunction

  // Monitor: pops expectations whenever the DUT presents a byte or pixel.
  always @(negedge HCLK) begin
    if (HRESETn) begin
      if (bus.byte_valid) begin
        if (byte_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_byte: got %0h dnc %0b, expected no byte", bus.byte_data, bus.byte_dnc);
        end else check("byte", {23'd0, bus.byte_dnc, bus.byte_data}, {23'd0, byte_q.pop_front()});
      end
      if (bus.pix_valid) begin
        pix_seen++;
        if (pix_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pixel: got (%0d,%0d)=%0h, expected no pixel", bus.pix_x, bus.pix_y, bus.pix_data);
        end else begin
          pix_t e;
          e = pix_q.pop_front();
          check("pixel", {2'd0, bus.pix_x, bus.pix_y, bus.pix_data}, {2'd0, e.x, e.y, e.d});
        end
      end
      if (bus.frame_err) ferr_seen++;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {bus.byte_valid, bus.byte_data, bus.byte_dnc, bus.pix_valid,
                           bus.pix_x, bus.pix_y, bus.inverse, bus.frame_err}, 32'd0);
    check({tag, "_pixdata"}, {16'd0, bus.pix_data}, 32'd0);
  endtask

  initial begin
    HRESETn = 1'b0;
    bus.nCS = 1'b1; bus.DnC = 1'b0; bus.SDIN = 1'b0; bus.SCLK = 1'b0;
    model_reset();
    repeat (3) tick();
    check_all_zero("reset");
    HRESETn = 1'b1;
    tick();

    // Column window, then a full 8x13 block write and one extra pixel.
    xfer(1'b0, 8'h15); xfer(1'b1, 8'h0E); xfer(1'b1, 8'h15);
    xfer(1'b0, 8'h75); xfer(1'b1, 8'h1F); xfer(1'b1, 8'h2B);
    xfer(1'b0, 8'h5C);
    pixels(104, 1'b0);
    pixels(1, 1'b0);
    tick(); tick();
    check("wrap_105th", {25'd0, bus.pix_x}, 32'd14);
    check("wrap_105th_y", {25'd0, bus.pix_y}, 32'd31);

    // Display mode with byte and inverse latency.
    xfer(1'b0, 8'hA7);
    check("byte_latency", {31'd0, bus.byte_valid}, 32'd1);
    tick();
    check("inverse_set", {31'd0, bus.inverse}, 32'd1);
    xfer(1'b0, 8'hA6);
    tick();
    check("inverse_clr", {31'd0, bus.inverse}, 32'd0);

    // Chip-select abort after 5 bits.
    send_bits(1'b0, 8'hA7, 5);
    bus.SCLK = 1'b0; bus.nCS = 1'b1;
    ferr_exp++;
    tick();
    check("frame_err_pulse", {31'd0, bus.frame_err}, 32'd1);
    tick();
    check("frame_err_single", {31'd0, bus.frame_err}, 32'd0);
    xfer(1'b0, 8'h75); xfer(1'b1, 8'h10); xfer(1'b1, 8'h20);
    xfer(1'b0, 8'h5C); pixels(2, 1'b1);

    // Orphan high byte followed by a command.
    xfer(1'b1, 8'hFF);
    xfer(1'b0, 8'h15); xfer(1'b1, 8'h03); xfer(1'b1, 8'h05);
    xfer(1'b0, 8'h5C); pixels(4, 1'b1);

    // Reset right after a pixel high byte.
    xfer(1'b0, 8'hA7);
    xfer(1'b0, 8'h5C); xfer(1'b1, 8'h12);
    repeat (3) tick();
    HRESETn = 1'b0;
    tick();
    HRESETn = 1'b1;
    model_reset();
    check_all_zero("midreset");
    xfer(1'b1, 8'h34);
    xfer(1'b0, 8'h5C); pixels(3, 1'b1);

    // Randomised command/data mix including aborts and inverted windows.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 7))
        0: begin xfer(1'b0, 8'h15); xfer(1'b1, rand_addr()); xfer(1'b1, rand_addr()); end
        1: begin xfer(1'b0, 8'h75); xfer(1'b1, rand_addr()); xfer(1'b1, rand_addr()); end
        2: begin xfer(1'b0, 8'h5C); pixels($urandom_range(1, 12), 1'b1); end
        3: xfer(1'b0, ($urandom_range(0, 1) == 0) ? 8'hA6 : 8'hA7);
        4: xfer(1'b0, 8'($urandom_range(0, 255)));
        5: xfer(1'b1, 8'($urandom_range(0, 255)));
        6: abort_after($urandom_range(1, 7));
        default: pixels($urandom_range(1, 8), 1'b1);
      endcase
      tick(); tick();
      check("inverse_rand", {31'd0, bus.inverse}, {31'd0, m_inv});
    end

    repeat (5) tick();
    check("bytes_drained", byte_q.size(), 32'd0);
    check("pixels_drained", pix_q.size(), 32'd0);
    check("pixel_count", pix_seen, pix_exp);
    check("frame_err_count", ferr_seen, ferr_exp);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
